uart_tx_arbiter: RTL and testbench



---
 rtl/uart_pkg.sv | 10 +
 rtl/rr_arbiter.sv | 25 ++
 rtl/uart_tx_arbiter.sv | 120 ++++++++++++
 tb/tb_uart_tx_arbiter.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: arbiter state encoding, HDLC framing constants and grant-width helper.
package uart_pkg;
    typedef enum logic [2:0] {IDLE, FETCH, SEND, GUARD, OPEN, ESC2, CLOSE} arb_state_t;
    localparam logic [7:0] HDLC_FLAG = 8'h7E;
    localparam logic [7:0] HDLC_ESC  = 8'h7D;
    localparam logic [7:0] HDLC_XOR  = 8'h20;
    function automatic int gid_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: picks the first valid index at or after ptr, wrapping, with a found flag.
module rr_arbiter #(
    parameter int N = 4,
    parameter int W = 2
) (
    input  logic [N-1:0] valid,
    input  logic [W-1:0] ptr,
    output logic [W-1:0] pick,
    output logic         found
);
    logic [W-1:0] idx;
    always_comb begin
        pick  = '0;
        found = 1'b0;
        idx   = '0;
        // Scan from the farthest offset down so the nearest valid index wins.
        for (int k = N - 1; k >= 0; k--) begin
            idx = W'((int'(ptr) + k) % N);
            if (valid[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
    end
endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin, packet-atomic sharing of one uart_tx among NUM_REQ byte streams.
// Define UART_TX_ARB_FRAMING_EN for RFC1662 flag/escape framing (MAX_BURST is then ignored).
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int MAX_BURST = 16
) (
    input  logic                      mclk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [8*NUM_REQ-1:0]      req_data,
    input  logic [NUM_REQ-1:0]        req_last,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic                      tx_ready,
    output logic [7:0]                tx_data,
    output logic                      tx_strobe,
    output logic [gid_w(NUM_REQ)-1:0] grant_id,
    output logic                      busy
);
    localparam int GW = gid_w(NUM_REQ);

    arb_state_t    state, state_n, guard_n;
    logic [GW-1:0] rr_ptr, pick, next_ptr;
    logic          found, xfer, last_r, cur_last;
    logic [7:0]    burst, cur_byte;

    rr_arbiter #(.N(NUM_REQ), .W(GW)) u_rr (
        .valid (req_valid),
        .ptr   (rr_ptr),
        .pick  (pick),
        .found (found)
    );

    assign cur_byte  = req_data[{grant_id, 3'b000} +: 8];
    assign cur_last  = req_last[grant_id];
    assign req_ready = (state == FETCH) ? (NUM_REQ'(tx_ready) << grant_id) : '0;
    assign xfer      = |(req_valid & req_ready);
    assign next_ptr  = (grant_id == GW'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
    assign tx_strobe = (state == SEND);
    assign busy      = (state != IDLE);

`ifdef UART_TX_ARB_FRAMING_EN
    localparam arb_state_t START = OPEN;
    logic       esc_pend, closing, special;
    logic [7:0] esc_byte;
    assign special = (cur_byte == HDLC_FLAG) || (cur_byte == HDLC_ESC);
    assign guard_n = esc_pend ? ESC2 : closing ? IDLE : last_r ? CLOSE : FETCH;
`else
    localparam arb_state_t START = FETCH;
    // req_last coinciding with the burst limit simply ends the packet.
    assign guard_n = (last_r || burst == 8'(MAX_BURST)) ? IDLE : FETCH;
`endif

    always_ff @(posedge mclk or posedge reset)
        if (reset) state <= IDLE;
        else       state <= state_n;

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = found ? START : IDLE;
            FETCH:   state_n = xfer ? SEND : FETCH;
            SEND:    state_n = GUARD;
            GUARD:   state_n = guard_n;
            default: state_n = tx_ready ? SEND : state;
        endcase
    end

    always_ff @(posedge mclk or posedge reset) begin
        if (reset) begin
            tx_data  <= '0;
            grant_id <= '0;
            rr_ptr   <= '0;
            burst    <= '0;
            last_r   <= 1'b0;
`ifdef UART_TX_ARB_FRAMING_EN
            esc_pend <= 1'b0;
            closing  <= 1'b0;
            esc_byte <= '0;
`endif
        end else begin
            case (state)
                IDLE: if (found) begin
                    grant_id <= pick;
                    burst    <= '0;
                    last_r   <= 1'b0;
`ifdef UART_TX_ARB_FRAMING_EN
                    esc_pend <= 1'b0;
                    closing  <= 1'b0;
`endif
                end
                FETCH: if (xfer) begin
                    last_r <= cur_last;
                    burst  <= burst + 8'd1;
`ifdef UART_TX_ARB_FRAMING_EN
                    tx_data  <= special ? HDLC_ESC : cur_byte;
                    esc_byte <= cur_byte ^ HDLC_XOR;
                    esc_pend <= special;
`else
                    tx_data <= cur_byte;
`endif
                end
                GUARD: if (guard_n == IDLE) rr_ptr <= next_ptr;
`ifdef UART_TX_ARB_FRAMING_EN
                OPEN: if (tx_ready) tx_data <= HDLC_FLAG;
                ESC2: if (tx_ready) begin
                    tx_data  <= esc_byte;
                    esc_pend <= 1'b0;
                end
                CLOSE: if (tx_ready) begin
                    tx_data <= HDLC_FLAG;
                    closing <= 1'b1;
                end
`endif
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: scoreboard bench; stimulus pushes expected {grant_id, tx_data} per strobe.
module tb_uart_tx_arbiter;
    localparam int N = 4;

    logic         mclk = 1'b0;
    logic         reset = 1'b1;
    logic [N-1:0] req_valid, req_last, req_ready;
    logic [8*N-1:0] req_data;
    logic         tx_ready, tx_strobe, busy;
    logic [7:0]   tx_data;
    logic [1:0]   grant_id;

    logic [8:0]   mem [N][64];
    int           head [N] = '{default: 0};
    int           tail [N] = '{default: 0};
    logic [N-1:0] hold = '0;
    logic [9:0]   exp_q [$];
    int           total = 0, bad = 0, xfers = 0, tx_gap = 40;

    uart_tx_arbiter #(.NUM_REQ(N), .MAX_BURST(16)) dut (
        .mclk      (mclk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_last  (req_last),
        .req_ready (req_ready),
        .tx_ready  (tx_ready),
        .tx_data   (tx_data),
        .tx_strobe (tx_strobe),
        .grant_id  (grant_id),
        .busy      (busy)
    );

    always #5 mclk = ~mclk;

    task automatic check(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, req);
        end
    endtask

    task automatic load(input int i, input logic [7:0] b, input logic last);
        mem[i][tail[i]] = {last, b};
        tail[i]++;
    endtask

    task automatic expb(input int gid, input logic [7:0] b);
        exp_q.push_back({2'(gid), b});
    endtask

    task automatic pkt(input int i, input logic [63:0] b, input int n);
        logic [7:0] x;
        for (int k = 0; k < n; k++) load(i, b[8*k +: 8], k == n - 1);
`ifdef UART_TX_ARB_FRAMING_EN
        expb(i, 8'h7E);
        for (int k = 0; k < n; k++) begin
            x = b[8*k +: 8];
            if (x == 8'h7E || x == 8'h7D) begin
                expb(i, 8'h7D);
                expb(i, x ^ 8'h20);
            end else expb(i, x);
        end
        expb(i, 8'h7E);
`else
        for (int k = 0; k < n; k++) expb(i, b[8*k +: 8]);
`endif
    endtask

    function automatic logic pending();
        logic p = 1'b0;
        for (int i = 0; i < N; i++) p |= (head[i] != tail[i]);
        return p;
    endfunction

    task automatic drain(input int limit);
        int n = 0;
        while ((exp_q.size() != 0 || busy || pending()) && n < limit) begin
            @(negedge mclk);
            n++;
        end
        check("drain_timeout", int'(n < limit), 1);
    endtask

    task automatic wait_strobe(input int limit);
        int n = 0;
        do begin
            @(negedge mclk);
            n++;
        end while (!tx_strobe && n < limit);
        check("strobe_timeout", int'(tx_strobe), 1);
    endtask

    task automatic clear_src();
        for (int i = 0; i < N; i++) head[i] = tail[i];
        hold = '0;
    endtask

    task automatic do_reset();
        @(negedge mclk);
        reset = 1'b1;
        clear_src();
        repeat (2) @(negedge mclk);
        reset = 1'b0;
    endtask

    // Requester sources: present queue heads, pop on accepted transfers.
    initial begin
        logic [N-1:0] tk;
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;
        forever begin
            @(negedge mclk);
            tk = req_valid & req_ready;
            @(posedge mclk);
            #1;
            for (int i = 0; i < N; i++) begin
                if (tk[i]) head[i]++;
                req_valid[i]        = (head[i] != tail[i]) && !hold[i];
                req_data[8*i +: 8]  = mem[i][head[i]][7:0];
                req_last[i]         = mem[i][head[i]][8];
            end
        end
    end

    // uart_tx model: ready drops the cycle after a strobe and stays low tx_gap cycles.
    initial begin
        tx_ready = 1'b1;
        forever begin
            @(negedge mclk);
            if (tx_strobe) begin
                @(posedge mclk);
                #1 tx_ready = 1'b0;
                repeat (tx_gap) @(posedge mclk);
                #1 tx_ready = 1'b1;
            end
        end
    end

    initial begin
        logic       prev_ready = 1'b0, prev_strobe = 1'b0;
        logic [9:0] e;
        int         cyc = 0, xcyc = -10;
        forever begin
            @(negedge mclk);
            cyc++;
            if (tx_strobe) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_strobe: got %0h want none", {grant_id, tx_data});
                end else begin
                    e = exp_q.pop_front();
                    check("strobe_gid_data", int'({grant_id, tx_data}), int'(e));
                end
                check("ready_before_strobe", int'(prev_ready), 1);
                check("strobe_consecutive", int'(prev_strobe), 0);
`ifndef UART_TX_ARB_FRAMING_EN
                check("strobe_latency", cyc - xcyc, 1);
`endif
            end
            if (|(req_valid & req_ready)) begin
                xcyc = cyc;
                xfers++;
            end
            prev_ready  = tx_ready;
            prev_strobe = tx_strobe;
        end
    end

    initial begin
        int x0;
        repeat (3) @(negedge mclk);
        check("rst_strobe", int'(tx_strobe), 0);
        check("rst_data", int'(tx_data), 0);
        check("rst_ready", int'(req_ready), 0);
        check("rst_gid", int'(grant_id), 0);
        check("rst_busy", int'(busy), 0);
        reset = 1'b0;

        x0 = xfers;
        pkt(0, 64'h4241, 2);
        drain(3000);
        check("single_xfers", xfers - x0, 2);

        do_reset();
        tx_gap = 3;
        pkt(0, 64'h10, 1);
        pkt(1, 64'h20, 1);
        pkt(2, 64'h30, 1);
        pkt(3, 64'h40, 1);
        pkt(0, 64'h50, 1);
        drain(3000);

`ifndef UART_TX_ARB_FRAMING_EN
        for (int k = 1; k <= 20; k++) load(1, 8'(k), k == 20);
        load(2, 8'hA0, 1'b0);
        load(2, 8'hA1, 1'b1);
        for (int k = 1; k <= 16; k++) expb(1, 8'(k));
        expb(2, 8'hA0);
        expb(2, 8'hA1);
        for (int k = 17; k <= 20; k++) expb(1, 8'(k));
        drain(3000);
`endif

        tx_gap = 40;
        pkt(0, 64'h636261, 3);
        wait_strobe(500);
        hold[0] = 1'b1;
        pkt(3, 64'h71, 1);
        repeat (100) @(negedge mclk);
        check("hold_busy", int'(busy), 1);
        check("hold_gid", int'(grant_id), 0);
        hold[0] = 1'b0;
        drain(3000);

`ifdef UART_TX_ARB_FRAMING_EN
        x0 = xfers;
        pkt(1, 64'h7D7E01, 3);
        drain(3000);
        check("esc_xfers", xfers - x0, 3);
`endif

        pkt(2, 64'h91, 1);
        drain(3000);
        load(3, 8'hA1, 1'b0);
        load(3, 8'hA2, 1'b1);
`ifdef UART_TX_ARB_FRAMING_EN
        expb(3, 8'h7E);
`else
        expb(3, 8'hA1);
`endif
        wait_strobe(500);
        #1 reset = 1'b1;
        #1;
        check("midrst_strobe", int'(tx_strobe), 0);
        check("midrst_busy", int'(busy), 0);
        check("midrst_gid", int'(grant_id), 0);
        check("midrst_ready", int'(req_ready), 0);
        clear_src();
        @(negedge mclk);
        reset = 1'b0;
        pkt(0, 64'hB0, 1);
        pkt(3, 64'hB3, 1);
        drain(3000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
